// File: rtl/norm_lod_pipe.sv
// norm_lod_pipe: two-stage leading-one normaliser with valid/ready flow control.
// Stage 1 takes the magnitude and priority-encodes the leading one; stage 2
// left-shifts the magnitude so that leading one sits at the MSB.
module norm_lod_pipe #(
    parameter int DATA_W = 10,
    parameter int FRAC_W = 2,
    parameter int POS_W  = $clog2(DATA_W),
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_norm,
    output logic [POS_W-1:0]  out_pos,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic              out_sign
);

    logic              adv1, adv2, in_fire, s2_load;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_mag_q,   s1_mag_d;
    logic [POS_W-1:0]  s1_pos_q,   s1_pos_d;
    logic              s1_zero_q,  s1_zero_d;
    logic              s1_sign_q,  s1_sign_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] norm_q,     norm_d;
    logic [POS_W-1:0]  pos_q,      pos_d;
    logic [FRAC_W-1:0] frac_q,     frac_d;
    logic              zero_q,     zero_d;
    logic              sign_q,     sign_d;

    logic [DATA_W-1:0] mag;
    logic [POS_W-1:0]  enc_pos;
    logic [POS_W-1:0]  shift;
    logic [DATA_W-1:0] shifted;

    // Pipeline advance enables; in_ready is combinational from out_ready.
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
        in_fire  = in_valid && adv1;
        s2_load  = adv2 && s1_valid_q;
    end

    // Stage 1: magnitude, sign and leading-one priority encoder.
    always_comb begin
        mag = in_data;
        if (SIGNED && in_data[DATA_W-1]) begin
            mag = -in_data;
        end
        enc_pos = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (mag[i]) begin
                enc_pos = POS_W'(i);
            end
        end

        s1_valid_d = adv1 ? in_valid : s1_valid_q;
        s1_mag_d   = s1_mag_q;
        s1_pos_d   = s1_pos_q;
        s1_zero_d  = s1_zero_q;
        s1_sign_d  = s1_sign_q;
        if (in_fire) begin
            s1_mag_d  = mag;
            s1_pos_d  = enc_pos;
            s1_zero_d = (mag == '0);
            s1_sign_d = SIGNED ? in_data[DATA_W-1] : 1'b0;
        end
    end

    // Stage 2: shift the leading one up to the MSB and slice the fraction.
    always_comb begin
        shift   = POS_W'(DATA_W - 1) - s1_pos_q;
        shifted = s1_mag_q << shift;

        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        norm_d     = norm_q;
        pos_d      = pos_q;
        frac_d     = frac_q;
        zero_d     = zero_q;
        sign_d     = sign_q;
        if (s2_load) begin
            zero_d = s1_zero_q;
            sign_d = s1_sign_q;
            if (s1_zero_q) begin
                norm_d = '0;
                pos_d  = '0;
                frac_d = '0;
            end else begin
                norm_d = shifted;
                pos_d  = s1_pos_q;
                frac_d = shifted[DATA_W-2 -: FRAC_W];
            end
        end
    end

    // State registers; reset clears valids and all result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_pos_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            norm_q     <= '0;
            pos_q      <= '0;
            frac_q     <= '0;
            zero_q     <= 1'b0;
            sign_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mag_q   <= s1_mag_d;
            s1_pos_q   <= s1_pos_d;
            s1_zero_q  <= s1_zero_d;
            s1_sign_q  <= s1_sign_d;
            s2_valid_q <= s2_valid_d;
            norm_q     <= norm_d;
            pos_q      <= pos_d;
            frac_q     <= frac_d;
            zero_q     <= zero_d;
            sign_q     <= sign_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_norm  = norm_q;
    assign out_pos   = pos_q;
    assign out_frac  = frac_q;
    assign out_zero  = zero_q;
    assign out_sign  = sign_q;

endmodule
